decode_scoreboard_issue: RTL
============================

Name: decode_scoreboard_issue

Overview:
- Parametrised successor decode/issue stage. Holds the scalar register file, a per-register pending scoreboard and the condition code.
- Accepts pre-decoded operand/destination fields from fetch/decode. Performs hazard checks with same-cycle writeback bypass, then issues into a ready/valid output register toward execute.
- Generalises the earlier half-cycle decode:
  - single posedge timing
  - NUM_WB parallel writeback ports
  - WAW stall
  - flush with scoreboard repair
  - asynchronous reset

Parameters:
- NUM_REGS, 16, architectural scalar registers (power of 2, >=2); IDX_W = $clog2(NUM_REGS) is a localparam.
- REG_WIDTH, 16, register/data width.
- NUM_WB, 2, writeback ports (1..4).
- PAYLOAD_WIDTH, 40, opaque sideband passed to execute (PC, opcode, imm).

Ports:
- I_CLOCK  in  1  clock, all state on rising edge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_Valid  in  1  upstream instruction valid.
- O_InReady  out  1  instruction accepted this cycle (combinational).
- I_Src1Idx  in  IDX_W  source 1 register.
- I_Src1Use  in  1  source 1 read needed.
- I_Src2Idx  in  IDX_W  source 2 register.
- I_Src2Use  in  1  source 2 read needed.
- I_DestIdx  in  IDX_W  destination register.
- I_DestWrite  in  1  instruction writes destination.
- I_Payload  in  PAYLOAD_WIDTH  sideband.
- I_WbEnable  in  NUM_WB  per-port writeback enable.
- I_WbIdx  in  NUM_WB*IDX_W  packed writeback indices (port k at [k*IDX_W +: IDX_W]).
- I_WbData  in  NUM_WB*REG_WIDTH  packed writeback data.
- I_Flush  in  1  kill instruction held in output register.
- O_Valid  out  1  output register valid.
- I_Ready  in  1  execute accepts output.
- O_Src1Value  out  REG_WIDTH  source 1 operand.
- O_Src2Value  out  REG_WIDTH  source 2 operand.
- O_DestIdx  out  IDX_W  destination register.
- O_DestWrite  out  1  destination write flag.
- O_Payload  out  PAYLOAD_WIDTH  sideband.
- O_CC  out  3  {N,Z,P} of last written-back value.
- O_DepStall  out  1  I_Valid held back by a data hazard (combinational).
- O_PendingMask  out  NUM_REGS  scoreboard bits, for debug/fetch.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - RF all zero, pending all zero, O_CC=3'b000.
  - O_Valid=0; O_Src1Value, O_Src2Value, O_DestIdx, O_DestWrite, O_Payload all zero.
- Writeback, each posedge: for every enabled port k, RF[idx_k] <= data_k and pending[idx_k] cleared.
  - Two ports to the same index in one cycle: highest k wins. This is illegal upstream; the bench flags it.
- O_CC from the highest-index enabled port's data: N=msb, Z=all-zero, P otherwise. Unchanged if no port is enabled.
- Bypass: WbHit(r) is true if any enabled port targets r this cycle. Operand value comes from the winning port's data on WbHit, else RF[r].
- Hazards:
  - srcBusy = Use && pending[idx] && !WbHit(idx)
  - destBusy = I_DestWrite && pending[I_DestIdx] && !WbHit(I_DestIdx) (WAW stall)
  - O_DepStall = I_Valid && (src1Busy || src2Busy || destBusy)
- Acceptance: O_InReady = I_Valid && !O_DepStall && !I_Flush && (!O_Valid || I_Ready).
- On accept:
  - Output register loads operands (bypassed), dest fields and payload; O_Valid <= 1.
  - If I_DestWrite, pending[I_DestIdx] <= 1. This set wins over a same-cycle writeback clear of the same index.
- Unused source (Use=0): the value is still driven from RF/bypass but never stalls.
- Output handshake:
  - O_Valid && I_Ready without a new accept -> O_Valid <= 0.
  - While O_Valid && !I_Ready, all outputs hold stable.
- Flush: I_Flush has priority over accept and I_Ready.
  - O_Valid <= 0.
  - If O_Valid && O_DestWrite, pending[O_DestIdx] <= 0, unless a same-cycle writeback also clears it (same result).
  - No instruction is accepted in the flush cycle.
- Latency: accept to O_Valid is 1 cycle. Writeback to a dependent accept is 0 cycles (bypass).
- Registers are not hardwired; writes to any index, including 0, are legal.

Decomposition:
- Shared package decode_pkg:
  - CC encodings (CC_N=3'b100, CC_Z=3'b010, CC_P=3'b001)
  - payload field offsets (PC, opcode, imm)
  - default widths
- One natural sub-module: wb_bypass_mux. Given a read index, it returns WbHit and the winning port's data. Instantiated twice for the sources and reused for dest hit detection.

Test Plan:
- Reset then issue ADD R3<-R1,R2 (all zero, not pending) with I_Ready=1 -> accepted the same cycle, O_Valid=1 next cycle, operands 0, O_PendingMask=16'h0008.
- R3 pending; issue Src1=R3 -> O_DepStall=1 and O_InReady=0 until WB port0 writes R3=16'h8001. That same cycle: accept with O_Src1Value=16'h8001, O_CC=3'b100, bit 3 cleared.
- Ports 0 and 1 write R4=5 and R5=0 in the same cycle -> RF updated, O_CC=3'b010 (port1 data), pending bits 4 and 5 clear.
- R6 pending; issue with DestIdx=R6 -> WAW stall. When the WB of R6 arrives the same cycle, accept and bit 6 stays 1.
- O_Valid=1 holding DestIdx=R7 with I_Ready=0 for 3 cycles -> outputs stable. Then I_Flush=1 -> O_Valid=0, bit 7 cleared, no accept that cycle.
- Assert I_RESET asynchronously mid-stall with pending=16'hFFFF -> pending, O_Valid and O_CC zero immediately, before the next edge.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants for the decode/scoreboard/issue stage
package decode_pkg;

  localparam int DEF_NUM_REGS      = 16;
  localparam int DEF_REG_WIDTH     = 16;
  localparam int DEF_NUM_WB        = 2;
  localparam int DEF_PAYLOAD_WIDTH = 40;

  // Condition code encodings {N,Z,P}
  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  // Sideband payload field layout
  localparam int PAY_PC_LSB  = 0;
  localparam int PAY_PC_W    = 16;
  localparam int PAY_OPC_LSB = 16;
  localparam int PAY_OPC_W   = 8;
  localparam int PAY_IMM_LSB = 24;
  localparam int PAY_IMM_W   = 16;

endpackage

// File: rtl/wb_bypass_mux.sv
// rtl/wb_bypass_mux.sv - writeback hit detection and bypass data select for one read index
module wb_bypass_mux #(
  parameter int IDX_W     = 4,
  parameter int REG_WIDTH = 16,
  parameter int NUM_WB    = 2
) (
  input  logic [IDX_W-1:0]            i_rd_idx,
  input  logic [NUM_WB-1:0]           i_wb_enable,
  input  logic [NUM_WB*IDX_W-1:0]     i_wb_idx,
  input  logic [NUM_WB*REG_WIDTH-1:0] i_wb_data,
  output logic                        o_hit,
  output logic [REG_WIDTH-1:0]        o_data
);

  // Scan ports in ascending order so the highest-numbered matching port wins
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (i_wb_enable[k] && (i_wb_idx[k*IDX_W +: IDX_W] == i_rd_idx)) begin
        o_hit  = 1'b1;
        o_data = i_wb_data[k*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

endmodule

// File: rtl/decode_scoreboard_issue.sv
// rtl/decode_scoreboard_issue.sv - register file, pending scoreboard, hazard check and issue register
module decode_scoreboard_issue
  import decode_pkg::*;
#(
  parameter int  NUM_REGS      = DEF_NUM_REGS,
  parameter int  REG_WIDTH     = DEF_REG_WIDTH,
  parameter int  NUM_WB        = DEF_NUM_WB,
  parameter int  PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH,
  localparam int IDX_W         = $clog2(NUM_REGS)
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_Valid,
  output logic                        O_InReady,
  input  logic [IDX_W-1:0]            I_Src1Idx,
  input  logic                        I_Src1Use,
  input  logic [IDX_W-1:0]            I_Src2Idx,
  input  logic                        I_Src2Use,
  input  logic [IDX_W-1:0]            I_DestIdx,
  input  logic                        I_DestWrite,
  input  logic [PAYLOAD_WIDTH-1:0]    I_Payload,
  input  logic [NUM_WB-1:0]           I_WbEnable,
  input  logic [NUM_WB*IDX_W-1:0]     I_WbIdx,
  input  logic [NUM_WB*REG_WIDTH-1:0] I_WbData,
  input  logic                        I_Flush,
  output logic                        O_Valid,
  input  logic                        I_Ready,
  output logic [REG_WIDTH-1:0]        O_Src1Value,
  output logic [REG_WIDTH-1:0]        O_Src2Value,
  output logic [IDX_W-1:0]            O_DestIdx,
  output logic                        O_DestWrite,
  output logic [PAYLOAD_WIDTH-1:0]    O_Payload,
  output logic [2:0]                  O_CC,
  output logic                        O_DepStall,
  output logic [NUM_REGS-1:0]         O_PendingMask
);

  logic [REG_WIDTH-1:0]     r_rf [NUM_REGS];
  logic [NUM_REGS-1:0]      r_pending;
  logic [2:0]               r_cc;
  logic                     r_valid;
  logic [REG_WIDTH-1:0]     r_src1;
  logic [REG_WIDTH-1:0]     r_src2;
  logic [IDX_W-1:0]         r_dest_idx;
  logic                     r_dest_write;
  logic [PAYLOAD_WIDTH-1:0] r_payload;

  logic                     w_src1_hit;
  logic                     w_src2_hit;
  logic                     w_dest_hit;
  logic [REG_WIDTH-1:0]     w_src1_wb;
  logic [REG_WIDTH-1:0]     w_src2_wb;
  logic [REG_WIDTH-1:0]     w_dest_wb_unused;
  logic [REG_WIDTH-1:0]     w_src1_value;
  logic [REG_WIDTH-1:0]     w_src2_value;
  logic                     w_src1_busy;
  logic                     w_src2_busy;
  logic                     w_dest_busy;
  logic                     w_dep_stall;
  logic                     w_accept;
  logic [NUM_REGS-1:0]      w_pending_next;
  logic [2:0]               w_cc_next;
  logic [REG_WIDTH-1:0]     w_wb_word;

  wb_bypass_mux #(.IDX_W(IDX_W), .REG_WIDTH(REG_WIDTH), .NUM_WB(NUM_WB)) u_byp_src1 (
    .i_rd_idx    (I_Src1Idx),
    .i_wb_enable (I_WbEnable),
    .i_wb_idx    (I_WbIdx),
    .i_wb_data   (I_WbData),
    .o_hit       (w_src1_hit),
    .o_data      (w_src1_wb)
  );

  wb_bypass_mux #(.IDX_W(IDX_W), .REG_WIDTH(REG_WIDTH), .NUM_WB(NUM_WB)) u_byp_src2 (
    .i_rd_idx    (I_Src2Idx),
    .i_wb_enable (I_WbEnable),
    .i_wb_idx    (I_WbIdx),
    .i_wb_data   (I_WbData),
    .o_hit       (w_src2_hit),
    .o_data      (w_src2_wb)
  );

  // Only the hit flag matters for the destination; its data output is left dangling
  wb_bypass_mux #(.IDX_W(IDX_W), .REG_WIDTH(REG_WIDTH), .NUM_WB(NUM_WB)) u_byp_dest (
    .i_rd_idx    (I_DestIdx),
    .i_wb_enable (I_WbEnable),
    .i_wb_idx    (I_WbIdx),
    .i_wb_data   (I_WbData),
    .o_hit       (w_dest_hit),
    .o_data      (w_dest_wb_unused)
  );

  assign w_src1_value = w_src1_hit ? w_src1_wb : r_rf[I_Src1Idx];
  assign w_src2_value = w_src2_hit ? w_src2_wb : r_rf[I_Src2Idx];

  // A pending register is only a hazard if no writeback resolves it this cycle
  assign w_src1_busy = I_Src1Use   && r_pending[I_Src1Idx] && !w_src1_hit;
  assign w_src2_busy = I_Src2Use   && r_pending[I_Src2Idx] && !w_src2_hit;
  assign w_dest_busy = I_DestWrite && r_pending[I_DestIdx] && !w_dest_hit;
  assign w_dep_stall = I_Valid && (w_src1_busy || w_src2_busy || w_dest_busy);
  assign w_accept    = I_Valid && !w_dep_stall && !I_Flush && (!r_valid || I_Ready);

  // Scoreboard next state: writeback clears, flush repair, then accept set wins
  always_comb begin
    w_pending_next = r_pending;
    for (int k = 0; k < NUM_WB; k++) begin
      if (I_WbEnable[k]) begin
        w_pending_next[I_WbIdx[k*IDX_W +: IDX_W]] = 1'b0;
      end
    end
    if (I_Flush && r_valid && r_dest_write) begin
      w_pending_next[r_dest_idx] = 1'b0;
    end
    if (w_accept && I_DestWrite) begin
      w_pending_next[I_DestIdx] = 1'b1;
    end
  end

  // Condition code follows the highest-numbered enabled writeback port
  always_comb begin
    w_cc_next = r_cc;
    w_wb_word = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (I_WbEnable[k]) begin
        w_wb_word = I_WbData[k*REG_WIDTH +: REG_WIDTH];
        if (w_wb_word[REG_WIDTH-1]) begin
          w_cc_next = CC_N;
        end else if (w_wb_word == '0) begin
          w_cc_next = CC_Z;
        end else begin
          w_cc_next = CC_P;
        end
      end
    end
  end

  // Register file writes; later ports overwrite earlier ones on an index clash
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (I_WbEnable[k]) begin
          r_rf[I_WbIdx[k*IDX_W +: IDX_W]] <= I_WbData[k*REG_WIDTH +: REG_WIDTH];
        end
      end
    end
  end

  // Scoreboard and condition code state
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      r_pending <= '0;
      r_cc      <= 3'b000;
    end else begin
      r_pending <= w_pending_next;
      r_cc      <= w_cc_next;
    end
  end

  // Issue register toward execute; flush beats both accept and drain
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      r_valid      <= 1'b0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_dest_idx   <= '0;
      r_dest_write <= 1'b0;
      r_payload    <= '0;
    end else if (I_Flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_src1       <= w_src1_value;
      r_src2       <= w_src2_value;
      r_dest_idx   <= I_DestIdx;
      r_dest_write <= I_DestWrite;
      r_payload    <= I_Payload;
    end else if (r_valid && I_Ready) begin
      r_valid <= 1'b0;
    end
  end

  assign O_InReady     = w_accept;
  assign O_DepStall    = w_dep_stall;
  assign O_Valid       = r_valid;
  assign O_Src1Value   = r_src1;
  assign O_Src2Value   = r_src2;
  assign O_DestIdx     = r_dest_idx;
  assign O_DestWrite   = r_dest_write;
  assign O_Payload     = r_payload;
  assign O_CC          = r_cc;
  assign O_PendingMask = r_pending;

endmodule
